// File: rtl/ram_tester_pkg.sv
// Shared types and constants for the RAM pattern BIST sequencer.
package ram_tester_pkg;

  localparam int DEPTH = 256;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [1:0] MODE_ADDR  = 2'd0;
  localparam logic [1:0] MODE_INV   = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/ram_pattern_gen.sv
// Pattern source for the BIST: one instance is reloaded between the write and
// read passes so both passes see the same sequence.
module ram_pattern_gen
  import ram_tester_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          advance,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] pattern
);

  logic [AW-1:0] cnt;
  logic [DW-1:0] lfsr;

  // Load wins over advance so the last write cycle can rewind for the read pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      lfsr <= DW'(1);
    end else if (load) begin
      cnt  <= '0;
      lfsr <= (seed == '0) ? DW'(1) : seed;
    end else if (advance) begin
      cnt  <= cnt + AW'(1);
      lfsr <= {lfsr[DW-2:0], ^(lfsr & DW'(LFSR_TAPS))};
    end
  end

  always_comb begin
    pattern = '0;
    case (mode)
      MODE_ADDR:  pattern = DW'(cnt);
      MODE_INV:   pattern = ~DW'(cnt);
      MODE_LFSR:  pattern = lfsr;
      MODE_CONST: pattern = seed;
      default:    pattern = '0;
    endcase
  end

endmodule

// File: rtl/ram_pattern_tester.sv
// BIST sequencer for a 256x8 single-port RAM: fill with a pattern, read back,
// compare against the regenerated stream one cycle behind the read.
module ram_pattern_tester
  import ram_tester_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_data,
  output logic          ram_ce,
  output logic          ram_wre,
  output logic          ram_oce,
  output logic          ram_reset,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_t        state, state_next;
  logic [AW-1:0] addr, addr_d;
  logic [1:0]    mode_r;
  logic [DW-1:0] seed_r, exp_d, pattern, gen_seed;
  logic          vld_d, first_seen, gen_load, gen_adv, mismatch;

  // While idle the generator loads straight from the inputs sampled with start.
  assign gen_seed = (state == S_IDLE) ? seed : seed_r;

  ram_pattern_gen #(.AW(AW), .DW(DW)) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (gen_load),
    .advance (gen_adv),
    .mode    (mode_r),
    .seed    (gen_seed),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    gen_load   = 1'b0;
    gen_adv    = 1'b0;
    ram_ce     = 1'b0;
    ram_wre    = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          gen_load   = 1'b1;
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        ram_ce  = 1'b1;
        ram_wre = 1'b1;
        gen_adv = 1'b1;
        if (addr == '1) begin
          gen_load   = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ: begin
        ram_ce  = 1'b1;
        gen_adv = 1'b1;
        if (addr == '1) state_next = S_DRAIN;
      end
      S_DRAIN: state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_next = S_IDLE;
  end

  assign mismatch  = vld_d && (ram_dout != exp_d);
  assign busy      = (state != S_IDLE);
  assign ram_ad    = addr;
  assign ram_din   = (state == S_WRITE) ? pattern : '0;
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

  // Start clears results last so it overrides any compare on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr           <= '0;
      addr_d         <= '0;
      mode_r         <= MODE_ADDR;
      seed_r         <= '0;
      exp_d          <= '0;
      vld_d          <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      first_seen     <= 1'b0;
      pass           <= 1'b0;
    end else begin
      exp_d  <= pattern;
      addr_d <= addr;
      vld_d  <= (state == S_READ) && !abort;
      if (state == S_WRITE || state == S_READ) addr <= addr + AW'(1);
      if (mismatch) begin
        err_count <= err_count + (AW+1)'(1);
        if (!first_seen) begin
          first_seen     <= 1'b1;
          first_err_addr <= addr_d;
          first_err_data <= ram_dout;
        end
      end
      if (state_next == S_DONE) pass <= (err_count == '0) && !mismatch;
      if (state == S_IDLE && start) begin
        addr           <= '0;
        mode_r         <= mode;
        seed_r         <= seed;
        vld_d          <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
        first_seen     <= 1'b0;
        pass           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_pattern_tester.sv
// Directed bench for ram_pattern_tester with a behavioural RAM that can inject
// read faults.
module tb_ram_pattern_tester;
  import ram_tester_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n, start, abort;
  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic          busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr, ram_ad;
  logic [DW-1:0] first_err_data, ram_din, ram_dout;
  logic          ram_ce, ram_wre, ram_oce, ram_reset;

  logic [DW-1:0] mem [0:DEPTH-1];
  int            fault_sel = 0;
  int            checks = 0;
  int            errors = 0;
  int            cyc;
  int            hits;

  always #5 clk = ~clk;

  ram_pattern_tester #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .ram_ce         (ram_ce),
    .ram_wre        (ram_wre),
    .ram_oce        (ram_oce),
    .ram_reset      (ram_reset),
    .ram_ad         (ram_ad),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout)
  );

  // 1: bit3 forced low, 2: bit3 forced high, 3: address 0xC3 reads 0x00
  function automatic logic [DW-1:0] faultify(input logic [DW-1:0] d, input logic [AW-1:0] a);
    case (fault_sel)
      1:       return d & 8'hF7;
      2:       return d | 8'h08;
      3:       return (a == 8'hC3) ? 8'h00 : d;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_ce && ram_wre)  mem[ram_ad] <= ram_din;
    if (ram_ce && !ram_wre) ram_dout    <= faultify(mem[ram_ad], ram_ad);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [DW-1:0] s);
    @(negedge clk);
    mode  = m;
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns the cycle index (cycle 1 follows the start edge) in which done is seen.
  task automatic waitDone(input int pulse_at, output int n);
    n = 1;
    while (!done && n < 700) begin
      if (n == pulse_at) begin
        start = 1'b1;
        mode  = MODE_INV;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
  endtask

  task automatic endTest();
    @(posedge clk);
    #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    mode    = MODE_ADDR;
    seed    = '0;
    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_err", err_count, 0);
    checkOutput("rst_ce_wre", {ram_ce, ram_wre}, 0);
    checkOutput("rst_oce_reset", {ram_oce, ram_reset}, 2'b10);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] mode 0 ideal RAM");
    fault_sel = 0;
    applyStimulus(MODE_ADDR, 8'h00);
    waitDone(0, cyc);
    checkOutput("m0_done_cycle", cyc, 514);
    checkOutput("m0_pass", pass, 1);
    checkOutput("m0_err", err_count, 0);
    checkOutput("m0_mem5a", mem[8'h5A], 8'h5A);
    endTest();

    $display("[TB] mode 2 seed 0x00");
    applyStimulus(MODE_LFSR, 8'h00);
    waitDone(0, cyc);
    checkOutput("m2_done_cycle", cyc, 514);
    checkOutput("m2_pass", pass, 1);
    checkOutput("m2_seq", {mem[0], mem[1], mem[2], mem[3], mem[4]}, 40'h0102040811);
    endTest();

    $display("[TB] mode 1 bit3 stuck low");
    fault_sel = 1;
    applyStimulus(MODE_INV, 8'h00);
    waitDone(0, cyc);
    checkOutput("s0_err", err_count, 128);
    checkOutput("s0_first_addr", first_err_addr, 8'h00);
    checkOutput("s0_first_data", first_err_data, 8'hF7);
    checkOutput("s0_pass", pass, 0);
    endTest();

    $display("[TB] mode 1 bit3 stuck high");
    fault_sel = 2;
    applyStimulus(MODE_INV, 8'h00);
    waitDone(0, cyc);
    checkOutput("s1_err", err_count, 128);
    checkOutput("s1_first_addr", first_err_addr, 8'h08);
    checkOutput("s1_first_data", first_err_data, 8'hFF);
    checkOutput("s1_pass", pass, 0);
    endTest();

    $display("[TB] mode 3 seed 0xA5, 0xC3 corrupted");
    fault_sel = 3;
    applyStimulus(MODE_CONST, 8'hA5);
    waitDone(0, cyc);
    checkOutput("c3_err", err_count, 1);
    checkOutput("c3_first_addr", first_err_addr, 8'hC3);
    checkOutput("c3_first_data", first_err_data, 8'h00);
    checkOutput("c3_pass", pass, 0);
    checkOutput("c3_mem", mem[8'h10], 8'hA5);
    endTest();

    $display("[TB] start re-pulsed during test");
    fault_sel = 0;
    applyStimulus(MODE_ADDR, 8'h00);
    waitDone(100, cyc);
    checkOutput("rs_done_cycle", cyc, 514);
    checkOutput("rs_pass", pass, 1);
    endTest();

    $display("[TB] abort in READ");
    applyStimulus(MODE_ADDR, 8'h00);
    repeat (299) begin
      @(posedge clk);
      #1;
    end
    checkOutput("ab_pre_ce", {ram_ce, ram_wre}, 2'b10);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("ab_ce_wre", {ram_ce, ram_wre}, 0);
    checkOutput("ab_busy", busy, 0);
    hits = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      if (done) hits++;
    end
    checkOutput("ab_no_done", hits, 0);

    $display("[TB] async reset in WRITE");
    applyStimulus(MODE_INV, 8'h00);
    repeat (149) begin
      @(posedge clk);
      #1;
    end
    checkOutput("ar_pre_ce", {ram_ce, ram_wre}, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_ce_wre", {ram_ce, ram_wre}, 0);
    checkOutput("ar_busy_done", {busy, done, pass}, 0);
    checkOutput("ar_oce_reset", {ram_oce, ram_reset}, 2'b10);
    checkOutput("ar_ad_din", {ram_ad, ram_din}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(MODE_INV, 8'h00);
    waitDone(0, cyc);
    checkOutput("ar_done_cycle", cyc, 514);
    checkOutput("ar_pass", pass, 1);
    checkOutput("ar_err", err_count, 0);
    endTest();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
